// File: rtl/reg_file_dump_ctrl.sv
// reg_file_dump_ctrl: dumps a register-file range as a byte stream over valid/ready
//
// Ports:
//   clk_i          system clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        request a dump (sampled only while idle)
//   abort_i        stop the dump at the next byte boundary
//   debug_addr_o   register-file debug read address
//   debug_data_i   combinational debug read data
//   byte_out_o     stream byte
//   byte_valid_o   byte_out_o holds a valid byte
//   byte_ready_i   sink accepts the byte
//   busy_o         high whenever not idle
//   done_o         one-cycle pulse when a dump completes or is aborted
module reg_file_dump_ctrl #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter bit          HEADER_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [4:0]  debug_addr_o,
    input  logic [31:0] debug_data_i,
    output logic [7:0]  byte_out_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
        $error("reg_file_dump_ctrl: need FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [4:0] FIRST    = FIRST_REG[4:0];
    localparam logic [4:0] LAST     = LAST_REG[4:0];
    localparam logic [2:0] LAST_IDX = HEADER_EN ? 3'd4 : 3'd3;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, FINISH} state_e;

    state_e      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] snap_q, snap_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        abort_q, abort_d;

    // Byte idx of a register's sequence: optional header, then MSB-first data.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [4:0] a,
                                        input logic [2:0] idx);
        logic [1:0] d;
        d = HEADER_EN ? 2'(idx - 3'd1) : idx[1:0];
        if (HEADER_EN && idx == 3'd0) return {3'b100, a};
        return d == 2'd0 ? w[31:24] : d == 2'd1 ? w[23:16] : d == 2'd2 ? w[15:8] : w[7:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= FIRST;
            snap_q  <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                abort_d = 1'b0;
                if (start_i) begin
                    state_d = LOAD;
                    addr_d  = FIRST;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = FINISH;
                end else begin
                    // The first byte comes straight from the read port since
                    // the snapshot only becomes visible after this edge.
                    snap_d  = debug_data_i;
                    cnt_d   = 3'd0;
                    byte_d  = pick(debug_data_i, addr_q, 3'd0);
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // An abort is remembered until the presented byte is accepted.
                abort_d = abort_q | abort_i;
                if (byte_ready_i) begin
                    if (abort_q || abort_i) begin
                        valid_d = 1'b0;
                        state_d = FINISH;
                    end else if (cnt_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        if (addr_q == LAST) begin
                            state_d = FINISH;
                        end else begin
                            addr_d  = addr_q + 5'd1;
                            state_d = LOAD;
                        end
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        byte_d = pick(snap_q, addr_q, cnt_q + 3'd1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                addr_d  = FIRST;
                valid_d = 1'b0;
                abort_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign debug_addr_o = addr_q;
    assign byte_out_o   = byte_q;
    assign byte_valid_o = valid_q;
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == FINISH;

endmodule

// File: tb/tb_reg_file_dump_ctrl.sv
// tb_reg_file_dump_ctrl: directed self-checking bench for reg_file_dump_ctrl
module tb_reg_file_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst, abort, ready;
    logic        start_a, start_b, start_c;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rf [32];

    logic [4:0]  addr_a, addr_b, addr_c;
    logic [31:0] data_a, data_b, data_c;
    logic [7:0]  byte_a, byte_b, byte_c;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    logic [7:0]  q_a [$];
    logic [7:0]  q_b [$];
    logic [7:0]  q_c [$];
    int          nd_a = 0, nd_b = 0, nd_c = 0;
    int          checks = 0, errors = 0;
    int          cyc, nd0;
    logic        pv;
    logic [7:0]  pb;
    logic [3:0]  pat = 4'b1001;
    logic [7:0]  exp_a [10] = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44,
                                8'h81, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    logic [7:0]  exp_c [5]  = '{8'h87, 8'h01, 8'h02, 8'h03, 8'h04};

    always #5 clk = ~clk;

    assign data_a = rf[addr_a];
    assign data_b = rf[addr_b];
    assign data_c = rf[addr_c];

    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    always @(posedge clk) begin
        if (!rst && valid_a && ready) q_a.push_back(byte_a);
        if (!rst && valid_b && ready) q_b.push_back(byte_b);
        if (!rst && valid_c && ready) q_c.push_back(byte_c);
        if (done_a) nd_a <= nd_a + 1;
        if (done_b) nd_b <= nd_b + 1;
        if (done_c) nd_c <= nd_c + 1;
    end

    reg_file_dump_ctrl #(.FIRST_REG(0), .LAST_REG(1), .HEADER_EN(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort),
        .debug_addr_o(addr_a), .debug_data_i(data_a), .byte_out_o(byte_a),
        .byte_valid_o(valid_a), .byte_ready_i(ready), .busy_o(busy_a), .done_o(done_a));

    reg_file_dump_ctrl #(.FIRST_REG(0), .LAST_REG(31), .HEADER_EN(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort),
        .debug_addr_o(addr_b), .debug_data_i(data_b), .byte_out_o(byte_b),
        .byte_valid_o(valid_b), .byte_ready_i(ready), .busy_o(busy_b), .done_o(done_b));

    reg_file_dump_ctrl #(.FIRST_REG(7), .LAST_REG(7), .HEADER_EN(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start_c), .abort_i(abort),
        .debug_addr_o(addr_c), .debug_data_i(data_c), .byte_out_o(byte_c),
        .byte_valid_o(valid_c), .byte_ready_i(ready), .busy_o(busy_c), .done_o(done_c));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = v;
        tick;
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; ready = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_valid_b", valid_b, 1'b0);
        chk("rst_done_b", done_b, 1'b0);
        chk("rst_byte_b", byte_b, 8'h00);
        chk("rst_addr_a", addr_a, 5'd0);
        chk("rst_addr_c", addr_c, 5'd7);

        // Two-register dump with headers, sink always ready.
        wr(5'd0, 32'h11223344);
        wr(5'd1, 32'hA5A5A5A5);
        wr(5'd7, 32'h01020304);
        ready = 1'b1;
        q_a.delete();
        start_a = 1'b1; tick; start_a = 1'b0;
        chk("a_load_valid", valid_a, 1'b0);
        chk("a_load_busy", busy_a, 1'b1);
        tick;
        chk("a_first_valid", valid_a, 1'b1);
        chk("a_first_byte", byte_a, 8'h80);
        cyc = 2;
        while (!done_a && cyc < 100) begin tick; cyc++; end
        chk("a_done_latency", cyc, 13);
        chk("a_done_busy", busy_a, 1'b1);
        chk("a_done_valid", valid_a, 1'b0);
        tick;
        chk("a_idle_busy", busy_a, 1'b0);
        chk("a_idle_done", done_a, 1'b0);
        chk("a_done_pulses", nd_a, 1);
        chk("a_count", q_a.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("a_byte_%0d", i), q_a[i], exp_a[i]);

        // Same dump with the sink stalling in a 1-0-0-1 pattern.
        q_a.delete();
        start_a = 1'b1; tick; start_a = 1'b0;
        for (int i = 0; i < 200 && !done_a; i++) begin
            ready = pat[i % 4];
            pv = valid_a;
            pb = byte_a;
            tick;
            if (pv && !ready) begin
                chk("a2_hold_valid", valid_a, 1'b1);
                chk("a2_hold_byte", byte_a, pb);
            end
        end
        ready = 1'b1;
        chk("a2_done", done_a, 1'b1);
        tick;
        chk("a2_count", q_a.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("a2_byte_%0d", i), q_a[i], exp_a[i]);
        chk("a2_done_pulses", nd_a, 2);

        // Single-register range; START and ABORT together while idle.
        q_c.delete();
        start_c = 1'b1; abort = 1'b1; tick; start_c = 1'b0; abort = 1'b0;
        chk("c_start_wins", busy_c, 1'b1);
        tick;
        chk("c_first_valid", valid_c, 1'b1);
        chk("c_first_byte", byte_c, 8'h87);
        cyc = 2;
        while (!done_c && cyc < 100) begin tick; cyc++; end
        chk("c_done_latency", cyc, 7);
        chk("c_addr_finish", addr_c, 5'd7);
        tick;
        chk("c_idle_busy", busy_c, 1'b0);
        chk("c_count", q_c.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("c_byte_%0d", i), q_c[i], exp_c[i]);

        // ABORT while in LOAD finishes with no byte issued.
        q_c.delete();
        start_c = 1'b1; tick; start_c = 1'b0;
        abort = 1'b1; tick; abort = 1'b0;
        chk("c_abort_load_done", done_c, 1'b1);
        chk("c_abort_load_valid", valid_c, 1'b0);
        tick;
        chk("c_abort_load_idle", busy_c, 1'b0);
        chk("c_abort_load_bytes", q_c.size(), 0);
        chk("c_done_pulses", nd_c, 2);

        // Full 32-register dump without headers, Ri = i.
        for (int i = 0; i < 32; i++) wr(i[4:0], i);
        q_b.delete();
        start_b = 1'b1; tick; start_b = 1'b0;
        cyc = 1;
        while (!done_b && cyc < 400) begin tick; cyc++; end
        chk("b_full_latency", cyc, 161);
        tick;
        chk("b_full_addr_end", addr_b, 5'd0);
        chk("b_full_idle", busy_b, 1'b0);
        chk("b_full_count", q_b.size(), 128);
        chk("b_full_last", q_b[127], 8'h1F);
        for (int i = 0; i < 32; i++)
            chk($sformatf("b_full_word_%0d", i),
                {q_b[4*i], q_b[4*i+1], q_b[4*i+2], q_b[4*i+3]}, i);

        // Snapshot vs. concurrent write on R2, then ABORT on R3's second data byte.
        wr(5'd2, 32'h000000FF);
        wr(5'd3, 32'h12345678);
        q_b.delete();
        start_b = 1'b1; tick; start_b = 1'b0;
        cyc = 0;
        while (!(addr_b == 5'd2 && valid_b) && cyc < 100) begin tick; cyc++; end
        chk("b_reach_r2", {31'd0, addr_b == 5'd2 && valid_b}, 1);
        wr(5'd2, 32'hDEADBEEF);
        while (q_b.size() < 13 && cyc < 200) begin tick; cyc++; end
        chk("b_reach_r3_b1", q_b.size(), 13);
        chk("b_r3_b1_byte", byte_b, 8'h34);
        ready = 1'b0; abort = 1'b1; tick; abort = 1'b0;
        start_b = 1'b1; tick; start_b = 1'b0;
        tick;
        chk("b_abort_hold_valid", valid_b, 1'b1);
        chk("b_abort_hold_byte", byte_b, 8'h34);
        chk("b_abort_hold_busy", busy_b, 1'b1);
        ready = 1'b1;
        tick;
        chk("b_abort_done", done_b, 1'b1);
        chk("b_abort_valid", valid_b, 1'b0);
        tick;
        chk("b_abort_idle", busy_b, 1'b0);
        tick;
        chk("b_no_restart", busy_b, 1'b0);
        chk("b_abort_count", q_b.size(), 14);
        chk("b_abort_last", q_b[13], 8'h34);
        chk("b_snapshot", {q_b[8], q_b[9], q_b[10], q_b[11]}, 32'h000000FF);

        // RESET in the middle of R5, then a fresh dump from R0.
        wr(5'd0, 32'hCAFEF00D);
        q_b.delete();
        nd0 = nd_b;
        start_b = 1'b1; tick; start_b = 1'b0;
        cyc = 0;
        while (!(addr_b == 5'd5 && valid_b) && cyc < 100) begin tick; cyc++; end
        chk("b_reach_r5", {31'd0, addr_b == 5'd5 && valid_b}, 1);
        rst = 1'b1; tick; rst = 1'b0;
        chk("b_rst_valid", valid_b, 1'b0);
        chk("b_rst_busy", busy_b, 1'b0);
        chk("b_rst_done", done_b, 1'b0);
        chk("b_rst_addr", addr_b, 5'd0);
        chk("b_rst_no_pulse", nd_b, nd0);
        start_b = 1'b1; tick; start_b = 1'b0;
        tick;
        chk("b_restart_valid", valid_b, 1'b1);
        chk("b_restart_byte", byte_b, 8'hCA);
        chk("b_restart_addr", addr_b, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
